// File: rtl/i2s_transmitter_param.sv
// Stereo I2S transmitter: internal sclk/lrclk generation, one-entry holding register, MSB-first serialiser.
// Optional I2S_TX_UNDERRUN_HOLD_EN: on underrun, re-send the previously transmitted pair instead of zeros.
module i2s_transmitter_param #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int SCLK_DIV = 4
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_left,
  input  logic [DATA_W-1:0] in_right,
  output logic              sclk,
  output logic              lrclk,
  output logic              sdout,
  output logic              underrun
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DIV_W   = $clog2(SCLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SCLK_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] BIT_LEFT  = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_MSB   = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_RIGHT = BIT_W'(SLOT_W);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               sclk_q, sclk_d;
  logic               lrclk_q, lrclk_d;
  logic               sdout_q, sdout_d;
  logic               underrun_q, underrun_d;
  logic               hold_full_q, hold_full_d;
  logic [DATA_W-1:0]  hold_left_q, hold_left_d;
  logic [DATA_W-1:0]  hold_right_q, hold_right_d;
  logic [FRAME_W-1:0] shift_q, shift_d;

  logic               fall_event;
  logic               frame_load;
  logic               accept;
  logic [DATA_W-1:0]  src_left, src_right;
  logic [FRAME_W-1:0] frame_word;

  // Samples sit left-justified in their slot; trailing slot bits are zero.
  function automatic logic [SLOT_W-1:0] to_slot(input logic [DATA_W-1:0] s);
    logic [SLOT_W-1:0] w;
    w = '0;
    w[SLOT_W-1 -: DATA_W] = s;
    return w;
  endfunction

  assign fall_event = (div_cnt_q == DIV_LAST);
  assign frame_load = fall_event && (bit_cnt_q == BIT_MSB);
  assign in_ready   = ~hold_full_q | frame_load;
  assign accept     = in_valid & in_ready;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  logic [DATA_W-1:0] last_left_q, last_right_q;

  always_ff @(posedge mclk) begin
    if (rst) begin
      last_left_q  <= '0;
      last_right_q <= '0;
    end else if (frame_load && hold_full_q) begin
      last_left_q  <= hold_left_q;
      last_right_q <= hold_right_q;
    end
  end
`endif

  always_comb begin
    src_left  = hold_left_q;
    src_right = hold_right_q;
    if (!hold_full_q) begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
      src_left  = last_left_q;
      src_right = last_right_q;
`else
      src_left  = '0;
      src_right = '0;
`endif
    end
  end

  assign frame_word = {to_slot(src_left), to_slot(src_right)};

  always_comb begin
    div_cnt_d    = fall_event ? '0 : div_cnt_q + DIV_W'(1);
    bit_cnt_d    = bit_cnt_q;
    sclk_d       = sclk_q;
    lrclk_d      = lrclk_q;
    sdout_d      = sdout_q;
    underrun_d   = 1'b0;
    shift_d      = shift_q;
    hold_full_d  = hold_full_q;
    hold_left_d  = hold_left_q;
    hold_right_d = hold_right_q;

    if (div_cnt_q == DIV_HALF) sclk_d = 1'b1;

    if (fall_event) begin
      sclk_d    = 1'b0;
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      if (bit_cnt_q == BIT_LEFT)  lrclk_d = 1'b0;
      if (bit_cnt_q == BIT_RIGHT) lrclk_d = 1'b1;
      // Load cycle drives the left MSB straight from the new frame word.
      if (frame_load) begin
        sdout_d    = frame_word[FRAME_W-1];
        shift_d    = frame_word << 1;
        underrun_d = ~hold_full_q;
      end else begin
        sdout_d = shift_q[FRAME_W-1];
        shift_d = shift_q << 1;
      end
    end

    // A same-cycle accept refills the register the load just drained.
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_left_d  = in_left;
      hold_right_d = in_right;
    end else if (frame_load) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      sclk_q       <= 1'b0;
      lrclk_q      <= 1'b1;
      sdout_q      <= 1'b0;
      underrun_q   <= 1'b0;
      shift_q      <= '0;
      hold_full_q  <= 1'b0;
      hold_left_q  <= '0;
      hold_right_q <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sclk_q       <= sclk_d;
      lrclk_q      <= lrclk_d;
      sdout_q      <= sdout_d;
      underrun_q   <= underrun_d;
      shift_q      <= shift_d;
      hold_full_q  <= hold_full_d;
      hold_left_q  <= hold_left_d;
      hold_right_q <= hold_right_d;
    end
  end

  assign sclk     = sclk_q;
  assign lrclk    = lrclk_q;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter_param.sv
// Bench for i2s_transmitter_param: cycle-arithmetic reference model (frames indexed by mclk time) for a
// default instance plus a 16/16/2 instance; directed scenarios followed by randomized pair traffic.
module tb_i2s_transmitter_param;
  localparam int D0 = 4;
  localparam int S0 = 32;
  localparam int W0 = 24;
  localparam int D1 = 2;
  localparam int S1 = 16;
  localparam int W1 = 16;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        rst, rst1;
  logic        in_valid, in_valid1;
  logic [23:0] in_left, in_right;
  logic [15:0] in_left1, in_right1;
  logic        in_ready, sclk, lrclk, sdout, underrun;
  logic        in_ready1, sclk1, lrclk1, sdout1, underrun1;

  i2s_transmitter_param #(.DATA_W(W0), .SLOT_W(S0), .SCLK_DIV(D0)) dut0 (
    .mclk(mclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .sclk(sclk), .lrclk(lrclk),
    .sdout(sdout), .underrun(underrun)
  );

  i2s_transmitter_param #(.DATA_W(W1), .SLOT_W(S1), .SCLK_DIV(D1)) dut1 (
    .mclk(mclk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_left(in_left1), .in_right(in_right1), .sclk(sclk1), .lrclk(lrclk1),
    .sdout(sdout1), .underrun(underrun1)
  );

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int t1       = 0;
  int epoch    = -1;
  bit running  = 1'b0;

  logic [23:0] fr_l [256];
  logic [23:0] fr_r [256];
  logic [23:0] m_hold_l, m_hold_r, m_last_l, m_last_r;
  bit          m_full;
  int          un_at;
  int          acc_t[$];

  task automatic chk(input string name, input logic act, input logic exp, input int tt);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0b expected=%0b", name, tt, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference timing: cycle t after reset release; fall event n lands at the end of cycle n*D+D-1.
  function automatic logic f_sclk(input int tt, input int d);
    return (tt % d) >= d / 2;
  endfunction

  function automatic logic f_lr(input int tt, input int d, input int s);
    if (tt / d == 0) return 1'b1;
    return ((tt / d - 1) % (2 * s)) >= s;
  endfunction

  // Frame k is loaded on fall event 2*s*k+1; returns -1 before any frame has started.
  function automatic int f_frame(input int tt, input int d, input int s);
    int n;
    n = tt / d - 1;
    if (n < 1) return -1;
    return (n - 1) / (2 * s);
  endfunction

  function automatic int f_pos(input int tt, input int d, input int s);
    return (tt / d - 2) % (2 * s);
  endfunction

  function automatic logic f_bit(input logic [23:0] l, input logic [23:0] r,
                                 input int p, input int s, input int w);
    int q;
    if (p < s) return (p < w) ? l[w-1-p] : 1'b0;
    q = p - s;
    return (q < w) ? r[w-1-q] : 1'b0;
  endfunction

  // Compare process: checks both instances on every falling mclk edge, then advances the models.
  initial begin
    forever begin
      @(negedge mclk);
      if (rst) begin
        running  = 1'b0;
        t        = 0;
        m_full   = 1'b0;
        m_last_l = '0;
        m_last_r = '0;
        un_at    = -1;
        for (int i = 0; i < 256; i++) begin
          fr_l[i] = '0;
          fr_r[i] = '0;
        end
      end else begin
        int  k, idx;
        bit  load, exp_rdy;
        logic exp_sd;
        if (!running) begin
          running = 1'b1;
          epoch++;
          t = 0;
        end
        k = f_frame(t, D0, S0);
        exp_sd = (k < 0) ? 1'b0 : f_bit(fr_l[k % 256], fr_r[k % 256], f_pos(t, D0, S0), S0, W0);
        load = ((t % D0) == D0 - 1) && (((t / D0) % (2 * S0)) == 1);
        exp_rdy = !m_full || load;
        chk("sclk", sclk, f_sclk(t, D0), t);
        chk("lrclk", lrclk, f_lr(t, D0, S0), t);
        chk("sdout", sdout, exp_sd, t);
        chk("underrun", underrun, t == un_at, t);
        chk("in_ready", in_ready, exp_rdy, t);

        if (epoch == 0) begin
          case (t)
            0:    begin chk("rst_sclk", sclk, 1'b0, t); chk("rst_lrclk", lrclk, 1'b1, t);
                        chk("rst_sdout", sdout, 1'b0, t); chk("rst_ready", in_ready, 1'b1, t); end
            1:    begin chk("lit_sclk_lo", sclk, 1'b0, t); chk("lit_lr_init", lrclk, 1'b1, t); end
            2:    chk("lit_sclk_hi", sclk, 1'b1, t);
            5:    chk("lit_lr_left", lrclk, 1'b0, t);
            37:   chk("lit_L_b7", sdout, 1'b0, t);
            41:   chk("lit_L_b8", sdout, 1'b1, t);
            45:   chk("lit_L_b9", sdout, 1'b1, t);
            49:   chk("lit_L_b10", sdout, 1'b0, t);
            131:  chk("lit_lr_131", lrclk, 1'b0, t);
            132:  chk("lit_lr_right", lrclk, 1'b1, t);
            185:  chk("lit_R_b12", sdout, 1'b1, t);
            229:  chk("lit_R_b23", sdout, 1'b1, t);
            233:  chk("lit_R_pad", sdout, 1'b0, t);
            259:  chk("lit_lr_259", lrclk, 1'b1, t);
            260:  chk("lit_lr_260", lrclk, 1'b0, t);
            300:  begin
                    chk_int("acc_count_ge3", (acc_t.size() >= 3) ? 1 : 0, 1);
                    if (acc_t.size() >= 3) begin
                      chk_int("acc_pair1_t", acc_t[0], 0);
                      chk_int("acc_pair2_t", acc_t[1], 7);
                      chk_int("acc_pair3_t", acc_t[2], 263);
                    end
                  end
            777:  chk("lit_ff_msb", sdout, 1'b1, t);
            1031: chk("lit_un_before", underrun, 1'b0, t);
            1032: chk("lit_un_pulse", underrun, 1'b1, t);
            1033: begin chk("lit_un_after", underrun, 1'b0, t);
                        chk("lit_un_data", sdout, HOLD, t); end
            default: ;
          endcase
        end else if (epoch == 1) begin
          case (t)
            0: begin chk("rrst_sclk", sclk, 1'b0, t); chk("rrst_lrclk", lrclk, 1'b1, t);
                     chk("rrst_sdout", sdout, 1'b0, t); chk("rrst_ready", in_ready, 1'b1, t);
                     chk("rrst_un", underrun, 1'b0, t); end
            7: chk("rlit_un_before", underrun, 1'b0, t);
            8: chk("rlit_un_pulse", underrun, 1'b1, t);
            9: chk("rlit_un_data", sdout, 1'b0, t);
            default: ;
          endcase
        end

        if (load) begin
          idx = ((t / D0) / (2 * S0)) % 256;
          if (m_full) begin
            fr_l[idx] = m_hold_l;
            fr_r[idx] = m_hold_r;
            m_last_l  = m_hold_l;
            m_last_r  = m_hold_r;
          end else begin
            fr_l[idx] = HOLD ? m_last_l : 24'h0;
            fr_r[idx] = HOLD ? m_last_r : 24'h0;
            un_at     = t + 1;
          end
          m_full = 1'b0;
        end
        if (in_valid && exp_rdy) begin
          m_hold_l = in_left;
          m_hold_r = in_right;
          m_full   = 1'b1;
          acc_t.push_back(t);
        end
        t++;
      end

      if (rst1) begin
        t1 = 0;
      end else begin
        int   k1;
        logic e1;
        k1 = f_frame(t1, D1, S1);
        if (k1 < 0 || (k1 > 0 && !HOLD)) e1 = 1'b0;
        else e1 = f_bit(24'h008001, 24'h007FFE, f_pos(t1, D1, S1), S1, W1);
        chk("d1_sclk", sclk1, f_sclk(t1, D1), t1);
        chk("d1_lrclk", lrclk1, f_lr(t1, D1, S1), t1);
        chk("d1_sdout", sdout1, e1, t1);
        chk("d1_underrun", underrun1, (t1 >= 68) && ((t1 - 4) % 64 == 0), t1);
        chk("d1_ready", in_ready1, !(t1 == 1 || t1 == 2), t1);
        case (t1)
          1:  chk("d1_lit_lr1", lrclk1, 1'b1, t1);
          2:  chk("d1_lit_lr2", lrclk1, 1'b0, t1);
          4:  chk("d1_lit_Lmsb", sdout1, 1'b1, t1);
          6:  chk("d1_lit_Lb1", sdout1, 1'b0, t1);
          34: chk("d1_lit_Llsb", sdout1, 1'b1, t1);
          36: chk("d1_lit_Rmsb", sdout1, 1'b0, t1);
          38: chk("d1_lit_Rb1", sdout1, 1'b1, t1);
          65: chk("d1_lit_lr65", lrclk1, 1'b1, t1);
          66: begin chk("d1_lit_lr66", lrclk1, 1'b0, t1); chk("d1_lit_Rlsb", sdout1, 1'b0, t1); end
          68: chk("d1_lit_un", underrun1, 1'b1, t1);
          default: ;
        endcase
        t1++;
      end
    end
  end

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    bit rdy;
    int n;
    rdy = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    do begin
      @(negedge mclk);
      rdy = in_ready;
      @(posedge mclk);
      #1;
      n++;
    end while (!rdy && n < 2000);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout t=%0d actual=no_ready expected=ready", t);
    end
    $display("push L=%h R=%h epoch=%0d t=%0d", l, r, epoch, t - 1);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_left  = 24'($urandom);
      in_right = 24'($urandom);
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic wait_until(input int tt);
    in_valid = 1'b0;
    while (t < tt) begin
      @(posedge mclk);
      #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    rst1      = 1'b1;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    in_left   = '0;
    in_right  = '0;
    in_left1  = '0;
    in_right1 = '0;
    repeat (3) @(posedge mclk);
    #1;
    rst  = 1'b0;
    rst1 = 1'b0;

    in_valid1 = 1'b1;
    in_left1  = 16'h8001;
    in_right1 = 16'h7FFE;
    offer(24'h00C491, 24'h000853);
    in_valid1 = 1'b0;
    offer(24'hA5A5A5, 24'h123456);
    offer(24'h3C3C3C, 24'h800001);
    offer(24'hFFFFFF, 24'hFFFFFF);
    in_valid = 1'b0;

    wait_until(1100);
    offer(24'($urandom), 24'($urandom));
    wait_until(1120);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge mclk);
    #1;
    rst = 1'b0;
    $display("mid-frame reset released");

    wait_until(20);
    for (int i = 0; i < 40; i++) begin
      idle_cycles($urandom_range(0, 600));
      offer(24'($urandom), 24'($urandom));
    end
    idle_cycles(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
